// File: rtl/halve_power_pkg.sv
// Shared RSA datapath types used by the halve_power stage.
package RSA_pkg;

  localparam int MOD_WIDTH = 256;

  typedef logic [31:0] IntType;

  // Request word: value is the most significant field, modulus the least.
  typedef struct packed {
    logic [MOD_WIDTH-1:0] value;
    IntType               power;
    logic [MOD_WIDTH-1:0] modulus;
  } HalvePowerIn;

  typedef logic [MOD_WIDTH-1:0] HalvePowerOut;

  typedef enum logic [1:0] {
    HP_IDLE = 2'd0,
    HP_RUN  = 2'd1,
    HP_DONE = 2'd2
  } hp_state_e;

  // Builds a request word from its three fields.
  function automatic HalvePowerIn hp_pack(input logic [MOD_WIDTH-1:0] value,
                                          input IntType               power,
                                          input logic [MOD_WIDTH-1:0] modulus);
    HalvePowerIn req;
    req.value   = value;
    req.power   = power;
    req.modulus = modulus;
    return req;
  endfunction

endpackage

// File: rtl/halve_power_step.sv
// One modular halving: (r odd ? r+N : r) / 2, with a carry-preserving adder.
module mod_halve_step #(
  parameter int MOD_WIDTH = RSA_pkg::MOD_WIDTH
) (
  input  logic [MOD_WIDTH-1:0] r_i,
  input  logic [MOD_WIDTH-1:0] n_i,
  output logic [MOD_WIDTH-1:0] half_o
);

  logic [MOD_WIDTH:0] sum_d;
  logic               unused_lsb_d;

  // Add N only for odd r so the sum is divisible by two; the extra bit keeps the carry.
  always_comb begin
    sum_d = {1'b0, r_i} + (r_i[0] ? {1'b0, n_i} : {(MOD_WIDTH+1){1'b0}});
  end

  assign {half_o, unused_lsb_d} = sum_d;

endmodule

// File: rtl/halve_power.sv
// value * 2^-power mod modulus, one modular halving per clock, valid/ready on both sides.
module halve_power #(
  parameter int MOD_WIDTH = RSA_pkg::MOD_WIDTH,
  parameter int POW_WIDTH = $bits(RSA_pkg::IntType)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_valid,
  output logic                             i_ready,
  input  logic [2*MOD_WIDTH+POW_WIDTH-1:0] i_in,
  output logic                             o_valid,
  input  logic                             o_ready,
  output logic [MOD_WIDTH-1:0]             o_out
);

  RSA_pkg::hp_state_e     state_q;
  logic [MOD_WIDTH-1:0]   r_q;
  logic [MOD_WIDTH-1:0]   n_q;
  logic [POW_WIDTH-1:0]   p_q;
  logic [POW_WIDTH-1:0]   cnt_q;
  logic                   o_valid_q;
  logic                   i_ready_q;

  logic [MOD_WIDTH-1:0]   in_value_d;
  logic [POW_WIDTH-1:0]   in_power_d;
  logic [MOD_WIDTH-1:0]   in_modulus_d;
  logic [MOD_WIDTH-1:0]   step_d;
  logic [POW_WIDTH:0]     cnt_next_d;

  // Field layout matches RSA_pkg::HalvePowerIn: {value, power, modulus}.
  assign in_value_d   = i_in[2*MOD_WIDTH+POW_WIDTH-1 -: MOD_WIDTH];
  assign in_power_d   = i_in[MOD_WIDTH+POW_WIDTH-1 -: POW_WIDTH];
  assign in_modulus_d = i_in[MOD_WIDTH-1:0];

  // Widened by one bit so cnt+1 == P is exact even for P = all-ones.
  assign cnt_next_d = {1'b0, cnt_q} + {{POW_WIDTH{1'b0}}, 1'b1};

  mod_halve_step #(
    .MOD_WIDTH(MOD_WIDTH)
  ) u_step (
    .r_i   (r_q),
    .n_i   (n_q),
    .half_o(step_d)
  );

  // Control FSM plus operand, counter and handshake registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RSA_pkg::HP_IDLE;
      r_q       <= {MOD_WIDTH{1'b0}};
      n_q       <= {MOD_WIDTH{1'b0}};
      p_q       <= {POW_WIDTH{1'b0}};
      cnt_q     <= {POW_WIDTH{1'b0}};
      o_valid_q <= 1'b0;
      i_ready_q <= 1'b1;
    end else begin
      case (state_q)
        RSA_pkg::HP_IDLE: begin
          if (i_valid) begin
            r_q       <= in_value_d;
            n_q       <= in_modulus_d;
            p_q       <= in_power_d;
            cnt_q     <= {POW_WIDTH{1'b0}};
            i_ready_q <= 1'b0;
            if (in_power_d == {POW_WIDTH{1'b0}}) begin
              state_q   <= RSA_pkg::HP_DONE;
              o_valid_q <= 1'b1;
            end else begin
              state_q   <= RSA_pkg::HP_RUN;
            end
          end
        end
        RSA_pkg::HP_RUN: begin
          r_q   <= step_d;
          cnt_q <= cnt_next_d[POW_WIDTH-1:0];
          if (cnt_next_d == {1'b0, p_q}) begin
            state_q   <= RSA_pkg::HP_DONE;
            o_valid_q <= 1'b1;
          end
        end
        RSA_pkg::HP_DONE: begin
          // r_q is frozen here, so the result stays stable under back-pressure.
          if (o_ready) begin
            state_q   <= RSA_pkg::HP_IDLE;
            o_valid_q <= 1'b0;
            i_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= RSA_pkg::HP_IDLE;
          o_valid_q <= 1'b0;
          i_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Ready is masked while reset is held so no request is offered a handshake.
  assign i_ready = i_ready_q & rst;
  assign o_valid = o_valid_q;
  assign o_out   = r_q;

endmodule

// File: tb/tb_halve_power.sv
// Self-checking bench for halve_power: vector table, corner sequences, random vs model.
module tb_halve_power;

  localparam int W8 = 8;
  localparam int PW = 32;
  localparam int WB = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic                      v8, rdy8, ov8, or8;
  logic [2*W8+PW-1:0]        in8;
  logic [W8-1:0]             out8;

  logic                      vb, rdyb, ovb, orb;
  logic [2*WB+PW-1:0]        inb;
  logic [WB-1:0]             outb;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  halve_power #(.MOD_WIDTH(W8), .POW_WIDTH(PW)) dut8 (
    .clk(clk), .rst(rst), .i_valid(v8), .i_ready(rdy8), .i_in(in8),
    .o_valid(ov8), .o_ready(or8), .o_out(out8)
  );

  halve_power dutb (
    .clk(clk), .rst(rst), .i_valid(vb), .i_ready(rdyb), .i_in(inb),
    .o_valid(ovb), .o_ready(orb), .o_out(outb)
  );

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // x * 2^-p mod n, computed as x * ((n+1)/2)^p mod n.
  function automatic logic [255:0] ref_model(input logic [255:0] x, input int unsigned p,
                                             input logic [255:0] n);
    logic [511:0] acc, inv2, nn;
    nn   = {256'd0, n};
    inv2 = (nn + 512'd1) >> 1;
    acc  = {256'd0, x} % nn;
    for (int i = 0; i < int'(p); i++) acc = (acc * inv2) % nn;
    return acc[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] x;
    x = 256'd0;
    for (int i = 0; i < 8; i++) x = {x[223:0], 32'($urandom())};
    return x;
  endfunction

  // One request through the 8-bit instance; result taken immediately.
  task automatic run8(input logic [7:0] val, input int unsigned p, input logic [7:0] m,
                      output logic [7:0] res, output int lat);
    int w;
    @(negedge clk);
    in8 = {val, p, m}; v8 = 1'b1; or8 = 1'b1;
    w = 0;
    while (!rdy8 && w < 100) begin @(negedge clk); w++; end
    @(posedge clk); #1; v8 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      if (lat == 1) chk("ready_low_after_accept8", {255'd0, rdy8}, 256'd0);
    end while (!ov8 && lat < 2000);
    res = out8;
    @(posedge clk); #1;
  endtask

  // One request through the 256-bit instance.
  task automatic runb(input logic [255:0] val, input int unsigned p, input logic [255:0] m,
                      output logic [255:0] res, output int lat);
    int w;
    @(negedge clk);
    inb = RSA_pkg::hp_pack(val, p, m); vb = 1'b1; orb = 1'b1;
    w = 0;
    while (!rdyb && w < 100) begin @(negedge clk); w++; end
    @(posedge clk); #1; vb = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ovb && lat < 2000);
    res = outb;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [7:0]  value;
    int unsigned power;
    logic [7:0]  modulus;
    logic [7:0]  expected;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0]   r8, m8, x8;
    logic [255:0] rb, nb, xb, pre;
    int           lat, p;
    bit           seen;

    vecs[0] = '{8'd1,   4, 8'd13,  8'd9};
    vecs[1] = '{8'd5,   0, 8'd13,  8'd5};
    vecs[2] = '{8'd249, 1, 8'd251, 8'd250};
    vecs[3] = '{8'd1,   1, 8'd13,  8'd7};
    vecs[4] = '{8'd12,  3, 8'd13,  8'd8};
    vecs[5] = '{8'd3,   2, 8'd13,  8'd4};
    vecs[6] = '{8'd253, 1, 8'd255, 8'd254};
    vecs[7] = '{8'd254, 1, 8'd255, 8'd127};
    vecs[8] = '{8'd250, 2, 8'd251, 8'd188};
    vecs[9] = '{8'd0,   3, 8'd1,   8'd0};

    v8 = 1'b0; or8 = 1'b0; in8 = '0;
    vb = 1'b0; orb = 1'b0; inb = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ovalid8", {255'd0, ov8}, 256'd0);
    chk("reset_oout8",   {248'd0, out8}, 256'd0);
    chk("reset_iready8", {255'd0, rdy8}, 256'd0);
    chk("reset_ovalidb", {255'd0, ovb}, 256'd0);
    chk("reset_ooutb",   outb, 256'd0);
    chk("reset_ireadyb", {255'd0, rdyb}, 256'd0);
    @(negedge clk); rst = 1'b1; #1;
    chk("release_iready8", {255'd0, rdy8}, 256'd1);
    chk("release_ireadyb", {255'd0, rdyb}, 256'd1);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      run8(vecs[i].value, vecs[i].power, vecs[i].modulus, r8, lat);
      chk($sformatf("vec%0d_out", i), {248'd0, r8}, {248'd0, vecs[i].expected});
      chk($sformatf("vec%0d_latency", i), 256'(lat), 256'(vecs[i].power + 1));
    end

    // Back-pressure: result held, i_valid ignored until the result handshake
    @(negedge clk);
    in8 = {8'd1, 32'd4, 8'd13}; v8 = 1'b1; or8 = 1'b0;
    @(posedge clk); #1; v8 = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ov8 && lat < 100);
    chk("bp_latency", 256'(lat), 256'd5);
    for (int k = 0; k < 5; k++) begin
      chk("bp_ovalid", {255'd0, ov8}, 256'd1);
      chk("bp_oout",   {248'd0, out8}, 256'd9);
      chk("bp_iready", {255'd0, rdy8}, 256'd0);
      in8 = {8'd2, 32'd1, 8'd13}; v8 = (k % 2 == 0);
      @(negedge clk);
    end
    chk("bp_oout_end", {248'd0, out8}, 256'd9);
    in8 = {8'd1, 32'd1, 8'd13}; v8 = 1'b1; or8 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_after_take_ovalid", {255'd0, ov8}, 256'd0);
    chk("bp_after_take_iready", {255'd0, rdy8}, 256'd1);
    @(posedge clk); #1; v8 = 1'b0;
    @(negedge clk);
    chk("bp_next_run_ovalid", {255'd0, ov8}, 256'd0);
    @(negedge clk);
    chk("bp_next_ovalid", {255'd0, ov8}, 256'd1);
    chk("bp_next_oout",   {248'd0, out8}, 256'd7);
    @(posedge clk); #1;

    // Reset in the 2nd RUN cycle aborts the request
    @(negedge clk);
    in8 = {8'd1, 32'd4, 8'd13}; v8 = 1'b1; or8 = 1'b1;
    @(posedge clk); #1; v8 = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b0; #1;
    chk("abort_iready_in_reset", {255'd0, rdy8}, 256'd0);
    @(negedge clk); rst = 1'b1; #1;
    chk("abort_iready_release", {255'd0, rdy8}, 256'd1);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ov8) seen = 1'b1;
    end
    chk("abort_no_ovalid", {255'd0, seen}, 256'd0);
    run8(8'd1, 1, 8'd13, r8, lat);
    chk("abort_next_out", {248'd0, r8}, 256'd7);
    chk("abort_next_latency", 256'(lat), 256'd2);

    // Random 8-bit requests vs model
    for (int i = 0; i < 16; i++) begin
      m8 = 8'($urandom_range(1, 255)) | 8'd1;
      x8 = 8'($urandom() % {24'd0, m8});
      p  = $urandom_range(0, 24);
      run8(x8, p, m8, r8, lat);
      chk($sformatf("rand8_%0d_out", i), {248'd0, r8}, ref_model({248'd0, x8}, p, {248'd0, m8}));
      chk($sformatf("rand8_%0d_latency", i), 256'(lat), 256'(p + 1));
    end

    // Random 256-bit requests vs model
    for (int i = 0; i < 6; i++) begin
      nb = rand256();
      nb[0] = 1'b1; nb[255] = 1'b1;
      xb = rand256() % nb;
      p  = (i < 3) ? 256 : $urandom_range(1, 64);
      runb(xb, p, nb, rb, lat);
      chk($sformatf("rand256_%0d_out", i), rb, ref_model(xb, p, nb));
      chk($sformatf("rand256_%0d_latency", i), 256'(lat), 256'(p + 1));
    end

    // Round trip with 2^256 mod N
    nb = rand256();
    nb[0] = 1'b1; nb[255] = 1'b1;
    pre = 256'd1;
    for (int i = 0; i < 256; i++) pre = 256'(({1'b0, pre} << 1) % {1'b0, nb});
    runb(pre, 256, nb, rb, lat);
    chk("roundtrip_256", rb, 256'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
